// File: rtl/game_pkg.sv
// Shared game constants and the tile encoding used by the map, the movement
// controller and the renderer.
package game_pkg;
  localparam int MAP_WIDTH  = 8;
  localparam int MAP_HEIGHT = 6;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FRAME   = 2'd1,
    PLAYER1 = 2'd2,
    PLAYER2 = 2'd3
  } tile_t;
endpackage

// File: rtl/map_writer_if.sv
// Bundle between the movement controller, the map writer and the renderer.
// Optional write-event signals are present when MAP_WRITER_EVENT_EN is defined.
interface map_writer_if
  import game_pkg::*;
#(
  parameter int W     = MAP_WIDTH,
  parameter int H     = MAP_HEIGHT,
  parameter int CNT_W = 16
);
  logic [1:0]       selected_player;
  logic [7:0]       current_x_1;
  logic [7:0]       current_y_1;
  logic [7:0]       current_x_2;
  logic [7:0]       current_y_2;
  logic             player1_collision;
  logic             player2_collision;
  tile_t            map [W][H];
  logic             map_ready;
  logic             oob_err;
  logic [CNT_W-1:0] trail_len_1;
  logic [CNT_W-1:0] trail_len_2;
`ifdef MAP_WRITER_EVENT_EN
  logic             wr_valid;
  logic [7:0]       wr_x;
  logic [7:0]       wr_y;
  tile_t            wr_tile;

  modport slave (
    input  selected_player, current_x_1, current_y_1, current_x_2, current_y_2,
           player1_collision, player2_collision,
    output map, map_ready, oob_err, trail_len_1, trail_len_2,
           wr_valid, wr_x, wr_y, wr_tile
  );
  modport master (
    output selected_player, current_x_1, current_y_1, current_x_2, current_y_2,
           player1_collision, player2_collision,
    input  map, map_ready, oob_err, trail_len_1, trail_len_2,
           wr_valid, wr_x, wr_y, wr_tile
  );
`else
  modport slave (
    input  selected_player, current_x_1, current_y_1, current_x_2, current_y_2,
           player1_collision, player2_collision,
    output map, map_ready, oob_err, trail_len_1, trail_len_2
  );
  modport master (
    output selected_player, current_x_1, current_y_1, current_x_2, current_y_2,
           player1_collision, player2_collision,
    input  map, map_ready, oob_err, trail_len_1, trail_len_2
  );
`endif
endinterface

// File: rtl/map_writer.sv
// Tile map owner: border sweep, head seeding, then trail painting per player.
// Define MAP_WRITER_EVENT_EN to add the per-write event stream for the renderer.
module map_writer
  import game_pkg::*;
#(
  parameter int W     = MAP_WIDTH,
  parameter int H     = MAP_HEIGHT,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  map_writer_if.slave bus
);
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [7:0] XMAX = 8'(W - 1);
  localparam logic [7:0] YMAX = 8'(H - 1);

  typedef enum logic [1:0] {CLEAR, SEED, RUN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sx_q, sx_d, sy_q, sy_d;
  logic [7:0]       px1_q, px1_d, py1_q, py1_d, px2_q, px2_d, py2_q, py2_d;
  logic             oob_q, oob_d;
  logic [CNT_W-1:0] tl1_q, tl1_d, tl2_q, tl2_d;
  tile_t            map_q [W][H];

  logic       we1, we2;
  logic [7:0] wx1, wy1, wx2, wy2;
  tile_t      wt1, wt2;
  logic       moved1, moved2, inb1, inb2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    px1_d   = px1_q;
    py1_d   = py1_q;
    px2_d   = px2_q;
    py2_d   = py2_q;
    oob_d   = oob_q;
    tl1_d   = tl1_q;
    tl2_d   = tl2_q;
    we1     = 1'b0;
    we2     = 1'b0;
    wx1     = bus.current_x_1;
    wy1     = bus.current_y_1;
    wt1     = PLAYER1;
    wx2     = bus.current_x_2;
    wy2     = bus.current_y_2;
    wt2     = PLAYER2;
    moved1  = (bus.current_x_1 != px1_q) || (bus.current_y_1 != py1_q);
    moved2  = (bus.current_x_2 != px2_q) || (bus.current_y_2 != py2_q);
    inb1    = (bus.current_x_1 <= XMAX) && (bus.current_y_1 <= YMAX);
    inb2    = (bus.current_x_2 <= XMAX) && (bus.current_y_2 <= YMAX);
    case (state_q)
      CLEAR: begin
        we1 = 1'b1;
        wx1 = sx_q;
        wy1 = sy_q;
        wt1 = (sx_q == 8'd0 || sx_q == XMAX || sy_q == 8'd0 || sy_q == YMAX) ? FRAME : EMPTY;
        if (sx_q == XMAX) begin
          sx_d = 8'd0;
          if (sy_q == YMAX) begin
            sy_d    = 8'd0;
            state_d = SEED;
          end else begin
            sy_d = sy_q + 8'd1;
          end
        end else begin
          sx_d = sx_q + 8'd1;
        end
      end
      SEED: begin
        // Out-of-range heads are latched but never index the map.
        we1     = inb1;
        we2     = inb2;
        px1_d   = bus.current_x_1;
        py1_d   = bus.current_y_1;
        px2_d   = bus.current_x_2;
        py2_d   = bus.current_y_2;
        tl1_d   = CNT_W'(1);
        tl2_d   = CNT_W'(1);
        oob_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (moved1) begin
          px1_d = bus.current_x_1;
          py1_d = bus.current_y_1;
          if (!inb1) oob_d = 1'b1;
          else if (!bus.player1_collision) begin
            we1   = 1'b1;
            tl1_d = sat_inc(tl1_q);
          end
        end
        if (moved2) begin
          px2_d = bus.current_x_2;
          py2_d = bus.current_y_2;
          if (!inb2) oob_d = 1'b1;
          else if (!bus.player2_collision) begin
            we2   = 1'b1;
            tl2_d = sat_inc(tl2_q);
          end
        end
        if (bus.selected_player == 2'b00) begin
          state_d = CLEAR;
          sx_d    = 8'd0;
          sy_d    = 8'd0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      sx_q    <= '0;
      sy_q    <= '0;
      px1_q   <= '0;
      py1_q   <= '0;
      px2_q   <= '0;
      py2_q   <= '0;
      oob_q   <= 1'b0;
      tl1_q   <= '0;
      tl2_q   <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      px1_q   <= px1_d;
      py1_q   <= py1_d;
      px2_q   <= px2_d;
      py2_q   <= py2_d;
      oob_q   <= oob_d;
      tl1_q   <= tl1_d;
      tl2_q   <= tl2_d;
    end
  end

  // Later assignment wins a shared cell: player 2 while seeding, player 1 in a round.
  always_ff @(posedge clk) begin
    if (state_q == SEED) begin
      if (we1) map_q[wx1[XW-1:0]][wy1[YW-1:0]] <= wt1;
      if (we2) map_q[wx2[XW-1:0]][wy2[YW-1:0]] <= wt2;
    end else begin
      if (we2) map_q[wx2[XW-1:0]][wy2[YW-1:0]] <= wt2;
      if (we1) map_q[wx1[XW-1:0]][wy1[YW-1:0]] <= wt1;
    end
  end

  assign bus.map         = map_q;
  assign bus.map_ready   = (state_q == RUN);
  assign bus.oob_err     = oob_q;
  assign bus.trail_len_1 = tl1_q;
  assign bus.trail_len_2 = tl2_q;

`ifdef MAP_WRITER_EVENT_EN
  logic       ev_vld_q, ev_vld_d, hold_vld_q, hold_vld_d;
  logic [7:0] ev_x_q, ev_x_d, ev_y_q, ev_y_d, hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  tile_t      ev_t_q, ev_t_d, hold_t_q, hold_t_d;

  // The second write of a cycle waits one cycle in the holding slot.
  always_comb begin
    ev_vld_d   = 1'b0;
    ev_x_d     = ev_x_q;
    ev_y_d     = ev_y_q;
    ev_t_d     = ev_t_q;
    hold_vld_d = hold_vld_q;
    hold_x_d   = hold_x_q;
    hold_y_d   = hold_y_q;
    hold_t_d   = hold_t_q;
    if (we1) begin
      ev_vld_d = 1'b1;
      ev_x_d   = wx1;
      ev_y_d   = wy1;
      ev_t_d   = wt1;
      if (we2) begin
        hold_vld_d = 1'b1;
        hold_x_d   = wx2;
        hold_y_d   = wy2;
        hold_t_d   = wt2;
      end
    end else if (hold_vld_q) begin
      ev_vld_d   = 1'b1;
      ev_x_d     = hold_x_q;
      ev_y_d     = hold_y_q;
      ev_t_d     = hold_t_q;
      hold_vld_d = we2;
      hold_x_d   = wx2;
      hold_y_d   = wy2;
      hold_t_d   = wt2;
    end else if (we2) begin
      ev_vld_d = 1'b1;
      ev_x_d   = wx2;
      ev_y_d   = wy2;
      ev_t_d   = wt2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_vld_q   <= 1'b0;
      ev_x_q     <= '0;
      ev_y_q     <= '0;
      ev_t_q     <= EMPTY;
      hold_vld_q <= 1'b0;
      hold_x_q   <= '0;
      hold_y_q   <= '0;
      hold_t_q   <= EMPTY;
    end else begin
      ev_vld_q   <= ev_vld_d;
      ev_x_q     <= ev_x_d;
      ev_y_q     <= ev_y_d;
      ev_t_q     <= ev_t_d;
      hold_vld_q <= hold_vld_d;
      hold_x_q   <= hold_x_d;
      hold_y_q   <= hold_y_d;
      hold_t_q   <= hold_t_d;
    end
  end

  assign bus.wr_valid = ev_vld_q;
  assign bus.wr_x     = ev_x_q;
  assign bus.wr_y     = ev_y_q;
  assign bus.wr_tile  = ev_t_q;
`endif
endmodule
